// File: rtl/miriscv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, status/control
// registers and a level "TX drained" interrupt.
module miriscv_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = AW + 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   baud_cnt, baud_n;
    logic [2:0]      bit_cnt, bit_n;
    logic [7:0]      shreg, sh_n;
    logic            tx_q, tx_n;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [NW-1:0]   count;
    logic            ovf, enable, irq_en;

    logic            sel, rd_sel;
    logic [1:0]      idx;
    logic            push_req, push_ok, pop, ovf_clr, ctrl_wr;
    logic            full, empty, busy, wrap;
    logic            unused_bits;

    assign sel      = data_req_i & (data_addr_i[31:4] == BASE_ADDR[31:4]);
    assign idx      = data_addr_i[3:2];
    assign rd_sel   = sel & ~data_we_i;
    assign push_req = sel & data_we_i & (idx == 2'd0) & data_be_i[0];
    assign ovf_clr  = sel & data_we_i & (idx == 2'd1) & data_be_i[0] & data_wdata_i[3];
    assign ctrl_wr  = sel & data_we_i & (idx == 2'd2) & data_be_i[0];

    assign full    = (count == NW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign busy    = (state != S_IDLE);
    // A simultaneous pop frees a slot, so a push to a full FIFO still lands
    assign push_ok = push_req & (~full | pop);
    assign wrap    = (baud_cnt == BAUD_MAX);

    assign unused_bits = ^{data_addr_i[1:0], data_be_i[3:1], data_wdata_i[31:8]};

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            enable <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
            if (push_req & full & ~pop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (ctrl_wr) begin
                enable <= data_wdata_i[0];
                irq_en <= data_wdata_i[1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= sh_n;
            tx_q     <= tx_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt + CW'(1);
        bit_n   = bit_cnt;
        sh_n    = shreg;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                baud_n = '0;
                if (enable & ~empty) begin
                    pop     = 1'b1;
                    sh_n    = mem[rd_ptr];
                    state_n = S_START;
                end
            end
            S_START: begin
                if (wrap) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (wrap) begin
                    baud_n = '0;
                    sh_n   = {1'b0, shreg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (wrap) begin
                    baud_n = '0;
                    // Chain straight into the next start bit when data is waiting
                    if (enable & ~empty) begin
                        pop     = 1'b1;
                        sh_n    = mem[rd_ptr];
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                baud_n  = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // Output bit is computed from the next state so tx_o is a clean register
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = sh_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_comb begin
        data_rdata_o = '0;
        if (rd_sel) begin
            case (idx)
                2'd1:    data_rdata_o = {23'b0, 5'(count), ovf, empty, full, busy};
                2'd2:    data_rdata_o = {30'b0, irq_en, enable};
                default: data_rdata_o = '0;
            endcase
        end
    end

    assign tx_o  = tx_q;
    assign irq_o = irq_en & empty & (state == S_IDLE);

endmodule

// File: tb/tb_miriscv_uart_tx.sv
// Directed self-checking bench for miriscv_uart_tx (CLK_DIV=4, FIFO_DEPTH=4).
module tb_miriscv_uart_tx;

    localparam logic [31:0] A_TX = 32'h0000_0100;
    localparam logic [31:0] A_ST = 32'h0000_0104;
    localparam logic [31:0] A_CT = 32'h0000_0108;
    localparam logic [31:0] A_RS = 32'h0000_010C;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        tx, irq;

    int checks   = 0;
    int failures = 0;

    miriscv_uart_tx #(
        .BASE_ADDR  (32'h0000_0100),
        .CLK_DIV    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_req_i   (req),
        .data_we_i    (we),
        .data_be_i    (be),
        .data_addr_i  (addr),
        .data_wdata_i (wdata),
        .data_rdata_o (rdata),
        .tx_o         (tx),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; be = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a; be = '0;
        #1;
        d = rdata;
        req = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    // Called 1ns after the edge that entered START; returns 1ns after the frame's last edge
    task automatic check_frame(input string tag, input logic [7:0] b);
        logic exp;
        for (int i = 0; i < 40; i++) begin
            int k;
            k = i / 4;
            if (k == 0)      exp = 1'b0;
            else if (k == 9) exp = 1'b1;
            else             exp = b[k-1];
            check(tag, {31'b0, tx}, {31'b0, exp});
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        saw_low;

        rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        check_reg("rst_status", A_ST, 32'h4);
        check("rst_tx", {31'b0, tx}, 32'h1);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check_reg("rst_ctrl", A_CT, 32'h0);

        // Register map corner cases
        check_reg("txdata_read", A_TX, 32'h0);
        check_reg("resv_read", A_RS, 32'h0);
        req = 1'b0; we = 1'b0; addr = A_ST; #1;
        check("unsel_read", rdata, 32'h0);
        wr(A_RS, 32'hFFFF_FFFF, 4'hF);
        wr(32'h0000_0200, 32'h77, 4'hF);
        wr(A_TX, 32'h77, 4'hE);
        check_reg("ignored_writes", A_ST, 32'h4);
        check_reg("ctrl_after_resv", A_CT, 32'h0);

        // Single byte
        wr(A_CT, 32'h1, 4'h1);
        wr(A_TX, 32'h55, 4'h1);
        check("no_pop_same_cycle_tx", {31'b0, tx}, 32'h1);
        check_reg("pushed_status", A_ST, 32'h10);
        @(posedge clk); #1;
        check_reg("popped_status", A_ST, 32'h5);
        check_frame("frame55", 8'h55);
        check_reg("after55_status", A_ST, 32'h4);

        // Back-to-back frames
        wr(A_CT, 32'h0, 4'h1);
        wr(A_TX, 32'hA5, 4'h1);
        wr(A_TX, 32'h3C, 4'h1);
        check_reg("b2b_count2", A_ST, 32'h20);
        wr(A_CT, 32'h1, 4'h1);
        @(posedge clk); #1;
        check_reg("b2b_count1", A_ST, 32'h11);
        check_frame("frameA5", 8'hA5);
        check_reg("b2b_count0", A_ST, 32'h5);
        check_frame("frame3C", 8'h3C);
        check_reg("b2b_done", A_ST, 32'h4);

        // Overflow
        wr(A_CT, 32'h0, 4'h1);
        for (int i = 1; i <= 5; i++) wr(A_TX, 32'(i), 4'h1);
        check_reg("ovf_status", A_ST, 32'h4A);
        wr(A_CT, 32'h1, 4'h1);
        @(posedge clk); #1;
        check_frame("ovf_f1", 8'h01);
        check_frame("ovf_f2", 8'h02);
        check_frame("ovf_f3", 8'h03);
        check_frame("ovf_f4", 8'h04);
        check_reg("ovf_drained", A_ST, 32'hC);
        repeat (8) @(posedge clk); #1;
        check("ovf_no_5th", {31'b0, tx}, 32'h1);
        wr(A_ST, 32'h8, 4'h1);
        check_reg("ovf_cleared", A_ST, 32'h4);

        // Interrupt
        wr(A_CT, 32'h3, 4'h1);
        check_reg("ctrl_readback", A_CT, 32'h3);
        check("irq_set", {31'b0, irq}, 32'h1);
        wr(A_TX, 32'h81, 4'h1);
        check("irq_after_push", {31'b0, irq}, 32'h0);
        @(posedge clk); #1;
        check("irq_in_frame", {31'b0, irq}, 32'h0);
        check_frame("frame81", 8'h81);
        check("irq_drained", {31'b0, irq}, 32'h1);

        // Reset mid-frame
        wr(A_CT, 32'h0, 4'h1);
        wr(A_TX, 32'hF0, 4'h1);
        wr(A_TX, 32'h12, 4'h1);
        wr(A_CT, 32'h1, 4'h1);
        @(posedge clk); #1;
        repeat (17) @(posedge clk); #1;
        check("bit3_low", {31'b0, tx}, 32'h0);
        #2 rst = 1'b1;
        #1 check("async_rst_tx", {31'b0, tx}, 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check_reg("rst2_status", A_ST, 32'h4);
        saw_low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx !== 1'b1) saw_low = 1'b1;
            @(posedge clk); #1;
        end
        check("rst2_quiet", {31'b0, saw_low}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
